// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: reads an operand pair from dual-port data memory, queues it, then steps the fetch unit.
// Optional build macro OPFETCH_STATS_EN adds a 16-bit pairs_done push counter port.
module operand_fetch_stage #(
  parameter int unsigned addrsize = 5,
  parameter int unsigned datasize = 8,
  parameter int unsigned depthlog = 2
) (
  input  logic                clk,
  input  logic                preset_n,
  input  logic [addrsize-1:0] addr0,
  input  logic [addrsize-1:0] addr1,
  input  logic                ready,
  output logic [2:0]          ctrlword,
  output logic                mem_rd,
  output logic [addrsize-1:0] mem_addr0,
  output logic [addrsize-1:0] mem_addr1,
  input  logic [datasize-1:0] mem_data0,
  input  logic [datasize-1:0] mem_data1,
  output logic                op_valid,
  input  logic                op_accept,
  output logic [datasize-1:0] op_a,
  output logic [datasize-1:0] op_b,
  output logic [addrsize-1:0] op_base,
  output logic [depthlog:0]   fill
`ifdef OPFETCH_STATS_EN
  ,
  output logic [15:0]         pairs_done
`endif
);

  localparam int unsigned depth = 2 ** depthlog;
  localparam logic [depthlog:0] depth_lvl = {1'b1, {depthlog{1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    READ,
    CAPTURE,
    STEP
  } state_t;

  state_t state, state_nxt;

  logic                push, pop;
  logic [depthlog-1:0] wr_ptr, rd_ptr;
  logic [datasize-1:0] buf_a    [depth];
  logic [datasize-1:0] buf_b    [depth];
  logic [addrsize-1:0] buf_base [depth];

  always_ff @(posedge clk or negedge preset_n) begin
    if (!preset_n) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_rd    = 1'b0;
    ctrlword  = 3'b000;
    case (state)
      IDLE:    if (ready && (fill < depth_lvl)) state_nxt = READ;
      READ: begin
        mem_rd    = 1'b1;
        state_nxt = CAPTURE;
      end
      CAPTURE: state_nxt = STEP;
      STEP: begin
        ctrlword  = 3'b111;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Addresses are captured on the edge entering READ so they are stable for
  // the whole read-strobe cycle, and held afterwards as the entry's tag.
  always_ff @(posedge clk or negedge preset_n) begin
    if (!preset_n) begin
      mem_addr0 <= '0;
      mem_addr1 <= '0;
    end else if ((state == IDLE) && (state_nxt == READ)) begin
      mem_addr0 <= addr0;
      mem_addr1 <= addr1;
    end
  end

  assign push     = (state == CAPTURE);
  assign op_valid = (fill != '0);
  assign pop      = op_valid && op_accept;

  always_ff @(posedge clk or negedge preset_n) begin
    if (!preset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_a[wr_ptr]    <= mem_data0;
      buf_b[wr_ptr]    <= mem_data1;
      buf_base[wr_ptr] <= mem_addr0;
    end
  end

  assign op_a    = buf_a[rd_ptr];
  assign op_b    = buf_b[rd_ptr];
  assign op_base = buf_base[rd_ptr];

`ifdef OPFETCH_STATS_EN
  always_ff @(posedge clk or negedge preset_n) begin
    if (!preset_n)  pairs_done <= '0;
    else if (push)  pairs_done <= pairs_done + 16'd1;
  end
`endif

endmodule

// File: doc/operand_fetch_stage.md
# operand_fetch_stage

Downstream neighbour of the data-pointer fetch unit. It samples the operand address pair (addr0, addr1) and issues a dual-port read to data memory. It captures the returned operand pair into a small FIFO, then drives the fetch unit's ctrlword to advance both pointers to the next pair. Execution units drain operand pairs from the FIFO through a valid/accept handshake.

## Interface
- addrsize, 5, width of data-memory addresses (matches fetch unit)
- datasize, 8, width of one operand
- depthlog, 2, log2 of FIFO depth (depth = 2**depthlog = 4)

- clk  in  1  clock; all state on posedge
- preset_n  in  1  reset; asynchronous, active-low
- addr0  in  addrsize  first operand address from fetch unit
- addr1  in  addrsize  second operand address from fetch unit
- ready  in  1  fetch unit pointers valid
- ctrlword  out  3  to fetch unit: {loadDP1, loadDP0, selMUXDP1}
- mem_rd  out  1  read strobe to data memory
- mem_addr0  out  addrsize  port-0 read address
- mem_addr1  out  addrsize  port-1 read address
- mem_data0  in  datasize  port-0 data, valid the cycle after mem_rd
- mem_data1  in  datasize  port-1 data, valid the cycle after mem_rd
- op_valid  out  1  FIFO head valid
- op_accept  in  1  consumer takes head
- op_a  out  datasize  head operand from addr0
- op_b  out  datasize  head operand from addr1
- op_base  out  addrsize  head's addr0 (tag)
- fill  out  depthlog+1  FIFO occupancy, 0..depth

## Operation
- FSM states and transitions:
  - IDLE: go to READ when ready=1 and fill<depth; otherwise stay.
  - READ: latch addr0/addr1 into mem_addr0/mem_addr1 registers; mem_rd=1 for exactly this cycle; go to CAPTURE.
  - CAPTURE: push {mem_data0, mem_data1, latched addr0} into the FIFO; go to STEP.
  - STEP: ctrlword=3'b111, for this cycle only; go to IDLE.
- Pointer advance: with ctrlword=3'b111, the fetch unit moves from (0,1) to (2,3) to (4,5) and so on.
- ctrlword is 3'b000 in every state except STEP.
- FIFO behaviour:
  - Circular, depth entries.
  - Push only in CAPTURE.
  - Pop when op_valid && op_accept.
  - Simultaneous push and pop leaves fill unchanged, with both pointers advancing.
- Head outputs: op_valid = (fill != 0). op_a, op_b and op_base show the head entry and are don't-care when op_valid=0.
- Full: admission is checked only in IDLE. Only one read is in flight at a time, so a push never overflows.
- Empty: op_accept is ignored and nothing pops.
- Address wrap: addresses wrap modulo 2**addrsize with no special handling. For example, (30,31) is followed by (0,1).
- ready drops while in READ, CAPTURE or STEP: the sequence completes anyway, and the next admission waits in IDLE.
- Reset while preset_n=0, taking effect immediately:
  - FSM to IDLE; fill=0; FIFO pointers=0.
  - mem_rd=0, ctrlword=0, mem_addr0/mem_addr1=0, op_valid=0.
  - Any in-flight read is discarded.

## Timing
- Throughput: one operand pair per 4 cycles when unthrottled.
- Latency:
  - mem_rd in READ at cycle n.
  - Data sampled at the posedge ending cycle n+1 (CAPTURE).
  - op_valid rises in cycle n+2 if the FIFO was empty.
  - ctrlword pulse in cycle n+2.
- Pointer settling: the fetch unit updates dp0/dp1 at the posedge ending STEP, and bp at the following negedge. The earliest next READ samples addr0/addr1 one full cycle after STEP (the IDLE cycle), so addresses are settled.
- Release from reset: preset_n deasserts asynchronously and the first FSM transition occurs on the first posedge after release.

## Configuration
- OPFETCH_STATS_EN:
  - Defined: adds output port pairs_done, 16 bits, reset 0. It increments by 1 on every FIFO push and wraps 16'hFFFF to 0.
  - Undefined: the port and counter do not exist, and all other behaviour is identical.

## Test plan
- Reset: hold preset_n=0 mid-READ. Required: mem_rd=0, ctrlword=0, fill=0 and op_valid=0 immediately, asynchronously.
- Single pair:
  - Stimulus: ready=1, addr=(0,1), memory[0]=8'h11, memory[1]=8'h22.
  - Required: mem_rd for 1 cycle; op_valid 2 cycles later with op_a=8'h11, op_b=8'h22, op_base=0; ctrlword=3'b111 for exactly 1 cycle; next read at (2,3).
- Backpressure: op_accept=0 for 20 cycles. Required: fill reaches 4, then no further mem_rd; one accept lets exactly one new read start.
- Simultaneous push/pop at fill=2: CAPTURE cycle with op_accept=1. Required: fill stays 2, head advances, FIFO order preserved.
- Wrap: addr=(30,31) then (0,1). Required: op_base sequence 30, 0; data correct.
- Stats (with OPFETCH_STATS_EN): 5 pairs pushed. Required: pairs_done=5; reset returns it to 0.
